// File: rtl/fpu_issue_ctrl.sv
// rtl/fpu_issue_ctrl.sv - operand FIFO and issue/capture sequencer for the half-precision FPU adder (optional FPU_ISSUE_STATS_EN)
module fpu_issue_ctrl #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_a,
    input  logic [15:0] in_b,
    output logic [15:0] Asem,
    output logic [15:0] Bsem,
    input  logic [15:0] Rsem,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_r
`ifdef FPU_ISSUE_STATS_EN
    ,
    output logic [15:0] stat_issued,
    output logic [15:0] stat_special
`endif
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ISSUE    = 2'd1,
        WAIT_OUT = 2'd2
    } state_t;

    localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    state_t        state, next_state;
    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          push, pop, capture, release_out;

    assign in_ready = (count != FULL_CNT);
    assign push     = in_valid && in_ready;

    always_comb begin
        next_state  = state;
        pop         = 1'b0;
        capture     = 1'b0;
        release_out = 1'b0;
        case (state)
            IDLE: begin
                if (count != '0) begin
                    pop        = 1'b1;
                    next_state = ISSUE;
                end
            end
            ISSUE: begin
                capture    = 1'b1;
                next_state = WAIT_OUT;
            end
            WAIT_OUT: begin
                if (out_ready) begin
                    release_out = 1'b1;
                    if (count != '0) begin
                        pop        = 1'b1;
                        next_state = ISSUE;
                    end else begin
                        next_state = IDLE;
                    end
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Storage carries no reset; validity is tracked solely by count and pointers.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {in_a, in_b};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            Asem      <= 16'h0000;
            Bsem      <= 16'h0000;
            out_r     <= 16'h0000;
            out_valid <= 1'b0;
        end else begin
            state <= next_state;
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
                Asem   <= mem[rd_ptr][31:16];
                Bsem   <= mem[rd_ptr][15:0];
            end
            if (push && !pop) begin
                count <= count + CNT_ONE;
            end else if (pop && !push) begin
                count <= count - CNT_ONE;
            end
            if (capture) begin
                out_r     <= Rsem;
                out_valid <= 1'b1;
            end else if (release_out) begin
                out_valid <= 1'b0;
            end
        end
    end

`ifdef FPU_ISSUE_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_issued  <= 16'h0000;
            stat_special <= 16'h0000;
        end else begin
            if (pop && stat_issued != 16'hFFFF) begin
                stat_issued <= stat_issued + 16'h0001;
            end
            if (capture && Rsem[14:10] == 5'b11111 && stat_special != 16'hFFFF) begin
                stat_special <= stat_special + 16'h0001;
            end
        end
    end
`endif

endmodule
